// File: rtl/microtile_scheduler.sv
// Round-robin / forced time-slice scheduler sharing one micro-tile slot among 4 tiles (IDLE -> RESET_HOLD -> RUN -> DRAIN).
// All outputs registered; optional grant statistics built when MICROTILE_SCHED_STATS_EN is defined.
module microtile_scheduler #(
    parameter int SLICE_CYCLES = 256,
    parameter int RST_HOLD     = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    input  logic       force_en,
    input  logic [1:0] force_sel,
    input  logic [1:0] stat_sel,
    output logic [1:0] sel,
    output logic [3:0] tile_rst_n,
    output logic [3:0] tile_clk_en,
    output logic       busy,
    output logic       switch_pulse,
    output logic [7:0] stat_out
);
    typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DRAIN} state_t;

    localparam int SW = (SLICE_CYCLES > 0) ? $clog2(SLICE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SLICE_LIM = SW'(SLICE_CYCLES);

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_grant_q, last_grant_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [7:0]    drain_cnt_q, drain_cnt_d;
    logic [SW-1:0] slice_cnt_q, slice_cnt_d;
    logic [3:0]    tile_rst_n_q, tile_rst_n_d;
    logic [3:0]    tile_clk_en_q, tile_clk_en_d;
    logic          busy_q, busy_d;
    logic          switch_pulse_q, switch_pulse_d;

    logic          rr_hit;
    logic [1:0]    rr_idx, rr_cand;
    logic [3:0]    tgt_oh, nxt_oh;
    logic [SW-1:0] slice_inc;
    logic          slice_hit, others_req, run_exit;

    // Scan offsets +4..+1 so the smallest offset from last_grant wins.
    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = last_grant_q;
        rr_cand = last_grant_q;
        for (int i = 4; i >= 1; i--) begin
            rr_cand = last_grant_q + 2'(i);
            if (req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        slice_cnt_d  = slice_cnt_q;
        tgt_oh       = 4'b0001 << sel_q;
        slice_inc    = slice_cnt_q + 1'b1;
        slice_hit    = (SLICE_CYCLES != 0) && (slice_inc == SLICE_LIM);
        others_req   = |(req & ~tgt_oh);
        run_exit     = done[sel_q]
                     || (!force_en && !req[sel_q])
                     || (force_en && (force_sel != sel_q))
                     || (!force_en && slice_hit && others_req);

        case (state_q)
            IDLE: begin
                if (force_en || rr_hit) begin
                    state_d      = RESET_HOLD;
                    sel_d        = force_en ? force_sel : rr_idx;
                    last_grant_d = sel_d;
                    hold_cnt_d   = 8'(RST_HOLD);
                end
            end
            RESET_HOLD: begin
                if (hold_cnt_q <= 8'd1) begin
                    state_d     = RUN;
                    slice_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            RUN: begin
                // Expiry with nobody waiting simply starts a fresh slice.
                slice_cnt_d = slice_hit ? '0 : slice_inc;
                if (run_exit) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 8'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (drain_cnt_q <= 8'd1) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        nxt_oh         = 4'b0001 << sel_d;
        tile_clk_en_d  = (state_d != IDLE) ? nxt_oh : 4'b0000;
        tile_rst_n_d   = (state_d == RUN || state_d == DRAIN) ? nxt_oh : 4'b0000;
        busy_d         = (state_d != IDLE);
        switch_pulse_d = (state_q == IDLE) && (state_d == RESET_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sel_q          <= 2'd0;
            last_grant_q   <= 2'd3;
            hold_cnt_q     <= 8'd0;
            drain_cnt_q    <= 8'd0;
            slice_cnt_q    <= '0;
            tile_rst_n_q   <= 4'b0000;
            tile_clk_en_q  <= 4'b0000;
            busy_q         <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            last_grant_q   <= last_grant_d;
            hold_cnt_q     <= hold_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            slice_cnt_q    <= slice_cnt_d;
            tile_rst_n_q   <= tile_rst_n_d;
            tile_clk_en_q  <= tile_clk_en_d;
            busy_q         <= busy_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign sel          = sel_q;
    assign tile_rst_n   = tile_rst_n_q;
    assign tile_clk_en  = tile_clk_en_q;
    assign busy         = busy_q;
    assign switch_pulse = switch_pulse_q;

`ifdef MICROTILE_SCHED_STATS_EN
    logic [7:0] grant_cnt_q [4];
    logic [7:0] grant_cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
        end
        if (switch_pulse_d && (grant_cnt_q[sel_d] != 8'hFF)) begin
            grant_cnt_d[sel_d] = grant_cnt_q[sel_d] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                grant_cnt_q[i] <= 8'd0;
            end else begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end

    assign stat_out = grant_cnt_q[stat_sel];
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_out        = 8'h00;
`endif

endmodule

// File: tb/tb_microtile_scheduler.sv
// Scoreboard bench for microtile_scheduler: expected grants queued at stimulus time, popped on switch_pulse.
module tb_microtile_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic       force_en = 1'b0;
    logic [1:0] force_sel = 2'd0;
    logic [1:0] stat_sel = 2'd0;
    logic [1:0] sel;
    logic [3:0] tile_rst_n;
    logic [3:0] tile_clk_en;
    logic       busy;
    logic       switch_pulse;
    logic [7:0] stat_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];
    logic [1:0] prev_sel = 2'd0;

`ifdef MICROTILE_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    microtile_scheduler #(.SLICE_CYCLES(8), .RST_HOLD(4), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .force_en(force_en),
        .force_sel(force_sel), .stat_sel(stat_sel), .sel(sel), .tile_rst_n(tile_rst_n),
        .tile_clk_en(tile_clk_en), .busy(busy), .switch_pulse(switch_pulse), .stat_out(stat_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ($countones(tile_clk_en) > 1) begin
                n_err++;
                $display("FAIL clk_en_onehot: got %b required at most one bit", tile_clk_en);
            end
            n_cmp++;
            if ((tile_rst_n & ~tile_clk_en) != 4'b0000) begin
                n_err++;
                $display("FAIL rst_without_clk: rst_n=%b clk_en=%b required rst_n subset of clk_en", tile_rst_n, tile_clk_en);
            end
            n_cmp++;
            if (!switch_pulse && sel !== prev_sel) begin
                n_err++;
                $display("FAIL sel_stable: sel %0d -> %0d without switch_pulse", prev_sel, sel);
            end
            if (switch_pulse) begin
                logic [1:0] e;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_order: unexpected grant sel=%0d required none", sel);
                end else begin
                    e = exp_q.pop_front();
                    if (sel !== e) begin
                        n_err++;
                        $display("FAIL grant_order: got sel=%0d required %0d", sel, e);
                    end
                end
            end
            if (!STATS) begin
                n_cmp++;
                if (stat_out !== 8'h00) begin
                    n_err++;
                    $display("FAIL stat_off: got %h required 00", stat_out);
                end
            end
        end
        prev_sel = sel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 4'b0000; force_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        for (int k = 0; k < 200 && busy; k++) tick();
        ok = !busy;
    endtask

    task automatic wait_run(output bit ok);
        for (int k = 0; k < 200 && tile_rst_n == 4'b0000; k++) tick();
        ok = (tile_rst_n != 4'b0000);
    endtask

    task automatic wait_pulse(output bit ok);
        for (int k = 0; k < 200 && !switch_pulse; k++) tick();
        ok = switch_pulse;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d required 0", sel); end
        n_cmp++; if (tile_rst_n !== 4'b0000) begin n_err++; $display("FAIL reset_rst_n: got %b required 0000", tile_rst_n); end
        n_cmp++; if (tile_clk_en !== 4'b0000) begin n_err++; $display("FAIL reset_clk_en: got %b required 0000", tile_clk_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (switch_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b required 0", switch_pulse); end
        n_cmp++; if (stat_out !== 8'h00) begin n_err++; $display("FAIL reset_stat: got %h required 00", stat_out); end
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        bit ok;
        exp_q.push_back(2'd0);
        req = 4'b0001;
        tick();
        n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL first_sel: got %0d required 0", sel); end
        n_cmp++; if (switch_pulse !== 1'b1) begin n_err++; $display("FAIL first_pulse: got %b required 1", switch_pulse); end
        n_cmp++; if (tile_clk_en !== 4'b0001) begin n_err++; $display("FAIL first_clk_en: got %b required 0001", tile_clk_en); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b required 1", busy); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (tile_rst_n !== 4'b0000 || tile_clk_en !== 4'b0001) begin
                n_err++;
                $display("FAIL hold_cycle%0d: rst_n=%b clk_en=%b required 0000/0001", i, tile_rst_n, tile_clk_en);
            end
            tick();
        end
        n_cmp++; if (tile_rst_n !== 4'b0001) begin n_err++; $display("FAIL run_rst_n: got %b required 0001", tile_rst_n); end
        req = 4'b0000;
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL first_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int cnt;
        do_reset();
        for (int g = 0; g < 5; g++) exp_q.push_back(2'(g));
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            n_cmp++; if (switch_pulse !== 1'b1) begin n_err++; $display("FAIL rr_pulse%0d: got %b required 1", g, switch_pulse); end
            cnt = 0;
            while (tile_clk_en != 4'b0000 && tile_rst_n == 4'b0000 && cnt < 50) begin cnt++; tick(); end
            n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL rr_hold%0d: got %0d cycles required 4", g, cnt); end
            if (g < 4) begin
                cnt = 0;
                while (tile_rst_n != 4'b0000 && cnt < 50) begin cnt++; tick(); end
                n_cmp++; if (cnt != 10) begin n_err++; $display("FAIL rr_run_drain%0d: got %0d cycles required 10", g, cnt); end
                cnt = 0;
                while (tile_clk_en == 4'b0000 && cnt < 50) begin cnt++; tick(); end
                n_cmp++; if (cnt != 1) begin n_err++; $display("FAIL rr_gap%0d: got %0d idle cycles required 1", g, cnt); end
            end
        end
        req = 4'b0000;
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_slice_no_preempt();
        bit ok;
        int bad;
        do_reset();
        exp_q.push_back(2'd2);
        req = 4'b0100;
        wait_run(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL solo_run: rst_n=%b required 0100", tile_rst_n); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (switch_pulse || tile_rst_n !== 4'b0100 || !busy) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL solo_keeps_running: got %0d bad cycles required 0", bad); end
        done = 4'b0100;
        tick();
        n_cmp++; if (tile_clk_en !== 4'b0100 || tile_rst_n !== 4'b0100) begin n_err++; $display("FAIL drain1: clk_en=%b rst_n=%b required 0100/0100", tile_clk_en, tile_rst_n); end
        done = 4'b0000; req = 4'b0000;
        tick();
        n_cmp++; if (busy !== 1'b1 || tile_clk_en !== 4'b0100) begin n_err++; $display("FAIL drain2: busy=%b clk_en=%b required 1/0100", busy, tile_clk_en); end
        tick();
        n_cmp++; if (busy !== 1'b0 || tile_clk_en !== 4'b0000 || tile_rst_n !== 4'b0000) begin n_err++; $display("FAIL drain_idle: busy=%b clk_en=%b rst_n=%b required 0/0000/0000", busy, tile_clk_en, tile_rst_n); end
    endtask

    task automatic test_force();
        bit ok;
        int bad;
        do_reset();
        exp_q.push_back(2'd1);
        req = 4'b0010;
        wait_run(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL force_pre_run: rst_n=%b required 0010", tile_rst_n); end
        tick(); tick();
        exp_q.push_back(2'd3);
        force_en = 1'b1; force_sel = 2'd3; req = 4'b0001;
        tick();
        n_cmp++; if (tile_clk_en !== 4'b0010 || tile_rst_n !== 4'b0010) begin n_err++; $display("FAIL force_drain: clk_en=%b rst_n=%b required 0010/0010", tile_clk_en, tile_rst_n); end
        wait_pulse(ok);
        n_cmp++; if (!ok || sel !== 2'd3) begin n_err++; $display("FAIL force_sel: pulse=%b sel=%0d required 1/3", ok, sel); end
        wait_run(ok);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (switch_pulse || tile_rst_n !== 4'b1000) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL force_hold: got %0d bad cycles required 0", bad); end
        done = 4'b1000;
        tick();
        done = 4'b0000; force_en = 1'b0; req = 4'b0000;
        n_cmp++; if (tile_clk_en !== 4'b1000 || tile_rst_n !== 4'b1000) begin n_err++; $display("FAIL force_done_drain: clk_en=%b rst_n=%b required 1000/1000", tile_clk_en, tile_rst_n); end
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL force_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            exp_q.push_back(2'd0);
            req = (phase == 0) ? 4'b0001 : 4'b1111;
            if (phase == 0) begin
                wait_run(ok);
                tick(); tick();
            end else begin
                wait_pulse(ok);
                tick();
            end
            rst = 1'b1; req = 4'b0000;
            tick();
            n_cmp++;
            if (sel !== 2'd0 || tile_clk_en !== 4'b0000 || tile_rst_n !== 4'b0000 || busy !== 1'b0 || switch_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset%0d: sel=%0d clk_en=%b rst_n=%b busy=%b pulse=%b required 0/0000/0000/0/0",
                         phase, sel, tile_clk_en, tile_rst_n, busy, switch_pulse);
            end
            tick();
            rst = 1'b0;
        end
        exp_q.push_back(2'd0);
        req = 4'b1111;
        wait_pulse(ok);
        n_cmp++; if (!ok || sel !== 2'd0) begin n_err++; $display("FAIL last_grant_reset: pulse=%b sel=%0d required 1/0", ok, sel); end
        req = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_stats();
        bit ok;
        int tmo;
        do_reset();
        req = 4'b0001; done = 4'b0001;
        tmo = 0;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(2'd0);
            wait_pulse(ok);
            if (!ok) tmo++;
            if (i == 9) begin
                n_cmp++;
                if (stat_out !== (STATS ? 8'd10 : 8'd0)) begin
                    n_err++;
                    $display("FAIL stat_count10: got %0d required %0d", stat_out, STATS ? 10 : 0);
                end
            end
            tick();
        end
        n_cmp++; if (tmo != 0) begin n_err++; $display("FAIL stat_grants: got %0d timeouts required 0", tmo); end
        req = 4'b0000; done = 4'b0000;
        wait_idle(ok);
        n_cmp++; if (stat_out !== (STATS ? 8'hFF : 8'h00)) begin n_err++; $display("FAIL stat_sat: got %h required %h", stat_out, STATS ? 8'hFF : 8'h00); end
        stat_sel = 2'd1;
        #1;
        n_cmp++; if (stat_out !== 8'h00) begin n_err++; $display("FAIL stat_tile1: got %h required 00", stat_out); end
        stat_sel = 2'd0;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_round_robin();
        test_slice_no_preempt();
        test_force();
        test_reset_mid();
        test_stats();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d grants outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
